ram_dual: RTL and testbench
===========================

Name: ram_dual

Overview:
- Parametrised on-FPGA block RAM for the F100-L soft processor.
- Port A reads and writes; port B is read-only. Port B serves instruction fetch or a peripheral, such as a video or UART DMA.
- Adds per-byte write enables, a read-valid strobe, a selectable 1- or 2-cycle read latency, and an optional hardware clear-after-reset sequence with a busy flag.
- Sits between the CPU memory bus decoder and the storage array; intended to infer iCE40 BlockRAM.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 11, address width; depth = 2^ADDR_WIDTH words.
- READ_LATENCY, 1, cycles from read request edge to data valid; legal values are 1 or 2.
- CLEAR_ON_RESET, 1, when 1 the block zeroes every word after reset; when 0, contents are untouched by reset.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- busy  output  1  high while the clear sequence runs; all requests are ignored while high.
- a_address  input  ADDR_WIDTH  port A word address.
- a_data_in  input  DATA_WIDTH  port A write data.
- a_byte_enable  input  DATA_WIDTH/8  per-byte write mask; bit i covers data bits [8i+7:8i].
- a_write_enable  input  1  port A write request.
- a_read_enable  input  1  port A read request.
- a_data_out  output  DATA_WIDTH  port A read data.
- a_data_valid  output  1  one-cycle strobe marking a_data_out valid.
- b_address  input  ADDR_WIDTH  port B word address.
- b_read_enable  input  1  port B read request.
- b_data_out  output  DATA_WIDTH  port B read data.
- b_data_valid  output  1  one-cycle strobe marking b_data_out valid.

Behaviour:
- Reset (sampled at clk edge while reset=1):
  - a_data_out=0, b_data_out=0, a_data_valid=0, b_data_valid=0, pipeline stages cleared.
  - clear_count=0.
  - busy=1 if CLEAR_ON_RESET else 0.
  - Array contents are not altered during reset itself.
- Clear state machine (CLEAR_ON_RESET=1):
  - States: CLEARING and READY; reset forces CLEARING.
  - In CLEARING: each cycle writes all-zero to storage[clear_count] via port A and increments clear_count.
  - When clear_count = 2^ADDR_WIDTH-1 is written: next state is READY and busy drops on that same edge. Total busy = 2^ADDR_WIDTH cycles after reset deasserts.
  - Reset asserted mid-clear restarts at address 0.
  - With CLEAR_ON_RESET=0: the FSM is permanently READY.
- While busy=1: a_*/b_* requests are dropped completely, with no write, no read and no valid strobe. Requests are not queued.
- Port A write (READY, a_write_enable=1):
  - Bytes with a_byte_enable[i]=1 are updated at the edge; the other bytes keep their value.
  - All-zero mask means no change.
  - Write has priority: if a_read_enable is also 1, no read occurs and no valid strobe is produced.
- Port A read (READY, a_read_enable=1, a_write_enable=0): the array is sampled at the edge.
  - READY_LATENCY=1: a_data_out/a_data_valid update on the same edge, so they are visible one cycle after the request.
  - READ_LATENCY=2: one extra register stage; data is visible two cycles after the request.
  - Back-to-back reads give one result per cycle, in order.
- Port B read: same latency rules as port A, fully independent of port A.
- Same-address collision (port A write and port B read on the same edge): port B returns the old (pre-write) data. Read-first is mandatory.
- Data hold: a_data_out/b_data_out hold their last read value when no read completes. data_valid is 0 in any cycle without a completing read.
- Address wrap: none is needed; the full address range is valid. Out-of-range is impossible by construction.

Test Plan:
- Clear after reset (ADDR_WIDTH=4, CLEAR_ON_RESET=1), preloaded with 16'hFFFF:
  - Pulse reset 1 cycle -> busy=1 for exactly 16 cycles.
  - Reading all 16 addresses after busy falls returns 16'h0000.
  - A write attempted during busy to address 3 with 16'h1234 -> address 3 still reads 0.
- Byte enables (port A, READ_LATENCY=1):
  - Write 16'hABCD mask 2'b11 to address 5, then 16'h1200 mask 2'b10 -> port A read of address 5 returns 16'h12CD.
  - a_data_valid is high exactly one cycle after the read request.
- Latency 2 pipelining:
  - Port B reads addresses 1,2,3 on consecutive cycles (contents 11,22,33) -> b_data_valid high on cycles +2,+3,+4 with data 11,22,33.
  - b_data_out holds 33 afterwards, with valid=0.
- Collision:
  - Address 7 holds 16'h0042; same edge port A writes 16'h0099 to 7 and port B reads 7 -> B returns 16'h0042.
  - The next B read of 7 returns 16'h0099.
- Write priority: a_write_enable=1 and a_read_enable=1 together -> write applied, a_data_valid stays 0.
- Reset mid-clear and no-clear mode:
  - Reset reasserted at clear cycle 8 -> a full 16-cycle busy restarts.
  - With CLEAR_ON_RESET=0, busy never rises and prior contents survive reset.

Source files
------------

// File: rtl/ram_dual.sv
// Dual-port block RAM for the F100-L: port A read/write with byte enables, port B read-only.
// Optional zero-fill after reset, 1- or 2-cycle registered reads with valid strobes.
`timescale 1ns/1ps

module ram_dual #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 11,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    busy,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [DATA_WIDTH-1:0]   a_data_in,
    input  logic [DATA_WIDTH/8-1:0] a_byte_enable,
    input  logic                    a_write_enable,
    input  logic                    a_read_enable,
    output logic [DATA_WIDTH-1:0]   a_data_out,
    output logic                    a_data_valid,
    input  logic [ADDR_WIDTH-1:0]   b_address,
    input  logic                    b_read_enable,
    output logic [DATA_WIDTH-1:0]   b_data_out,
    output logic                    b_data_valid
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {
        CLEARING = 1'b0,
        READY    = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clear_count;
    logic [DATA_WIDTH-1:0]   storage [DEPTH];

    logic                    ready;
    logic                    a_write;
    logic                    a_read;
    logic                    b_read;

    logic [DATA_WIDTH-1:0]   a_stage_data;
    logic                    a_stage_valid;
    logic [DATA_WIDTH-1:0]   b_stage_data;
    logic                    b_stage_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= (CLEAR_ON_RESET != 0) ? CLEARING : READY;
            clear_count <= '0;
        end else begin
            state <= state_next;
            if (state == CLEARING) begin
                clear_count <= clear_count + ADDR_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEARING: if (clear_count == '1) state_next = READY;
            READY:    state_next = READY;
            default:  state_next = READY;
        endcase
    end

    assign busy = (state == CLEARING);

    // Requests only count in READY and outside reset; a write masks a simultaneous port A read.
    assign ready   = (state == READY) && !reset;
    assign a_write = ready && a_write_enable;
    assign a_read  = ready && a_read_enable && !a_write_enable;
    assign b_read  = ready && b_read_enable;

    always_ff @(posedge clk) begin
        if (!reset && state == CLEARING) begin
            storage[clear_count] <= '0;
        end else if (a_write) begin
            for (int i = 0; i < BYTES; i++) begin
                if (a_byte_enable[i]) begin
                    storage[a_address][8*i +: 8] <= a_data_in[8*i +: 8];
                end
            end
        end
    end

    // Reads sample the array before this edge's write lands, giving read-first collisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_stage_data  <= '0;
            a_stage_valid <= 1'b0;
            b_stage_data  <= '0;
            b_stage_valid <= 1'b0;
        end else begin
            a_stage_valid <= a_read;
            b_stage_valid <= b_read;
            if (a_read) a_stage_data <= storage[a_address];
            if (b_read) b_stage_data <= storage[b_address];
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign a_data_out   = a_stage_data;
            assign a_data_valid = a_stage_valid;
            assign b_data_out   = b_stage_data;
            assign b_data_valid = b_stage_valid;
        end else begin : g_lat2
            logic [DATA_WIDTH-1:0] a_out_data;
            logic                  a_out_valid;
            logic [DATA_WIDTH-1:0] b_out_data;
            logic                  b_out_valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_out_data  <= '0;
                    a_out_valid <= 1'b0;
                    b_out_data  <= '0;
                    b_out_valid <= 1'b0;
                end else begin
                    a_out_valid <= a_stage_valid;
                    b_out_valid <= b_stage_valid;
                    if (a_stage_valid) a_out_data <= a_stage_data;
                    if (b_stage_valid) b_out_data <= b_stage_data;
                end
            end

            assign a_data_out   = a_out_data;
            assign a_data_valid = a_out_valid;
            assign b_data_out   = b_out_data;
            assign b_data_valid = b_out_valid;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dual.sv
// Bench for ram_dual: three instances (lat1+clear, lat2+clear, lat1 no-clear) share one stimulus
// stream; a reference model predicts every output and directed checks pin key values.
`timescale 1ns/1ps

module tb_ram_dual;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int NI    = 3;

    logic          clk;
    logic          reset;
    logic [AW-1:0] a_address;
    logic [DW-1:0] a_data_in;
    logic [1:0]    a_byte_enable;
    logic          a_write_enable;
    logic          a_read_enable;
    logic [AW-1:0] b_address;
    logic          b_read_enable;

    logic [NI-1:0]         busy_o;
    logic [NI-1:0][DW-1:0] a_do;
    logic [NI-1:0]         a_dv;
    logic [NI-1:0][DW-1:0] b_do;
    logic [NI-1:0]         b_dv;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic bit clr_of(input int k);
        return (k != 2);
    endfunction

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    for (genvar g = 0; g < NI; g++) begin : g_dut
        ram_dual #(
            .DATA_WIDTH    (DW),
            .ADDR_WIDTH    (AW),
            .READ_LATENCY  ((g == 1) ? 2 : 1),
            .CLEAR_ON_RESET((g == 2) ? 0 : 1)
        ) dut (
            .clk           (clk),
            .reset         (reset),
            .busy          (busy_o[g]),
            .a_address     (a_address),
            .a_data_in     (a_data_in),
            .a_byte_enable (a_byte_enable),
            .a_write_enable(a_write_enable),
            .a_read_enable (a_read_enable),
            .a_data_out    (a_do[g]),
            .a_data_valid  (a_dv[g]),
            .b_address     (b_address),
            .b_read_enable (b_read_enable),
            .b_data_out    (b_do[g]),
            .b_data_valid  (b_dv[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mem_m  [NI][DEPTH];
    int            busy_left [NI];
    logic          ring_v [NI][2][4];
    logic [DW-1:0] ring_d [NI][2][4];
    logic          exp_v  [NI][2];
    logic [DW-1:0] exp_d  [NI][2];
    logic          exp_busy [NI];
    int            edge_n = 0;
    bit            live = 0;

    // Each edge produces at most one read result per port; it becomes visible LAT-1 edges later.
    task automatic model_edge(input int k);
        logic          av, bv;
        logic [DW-1:0] ad, bd, bm;
        int            src;
        av = 1'b0; bv = 1'b0; ad = '0; bd = '0;
        if (reset) begin
            busy_left[k] = clr_of(k) ? DEPTH : 0;
            for (int p = 0; p < 2; p++) begin
                exp_v[k][p] = 1'b0;
                exp_d[k][p] = '0;
                ring_v[k][p][edge_n & 3] = 1'b0;
            end
        end else begin
            if (busy_left[k] > 0) begin
                busy_left[k]--;
                if (busy_left[k] == 0)
                    for (int a = 0; a < DEPTH; a++) mem_m[k][a] = '0;
            end else begin
                if (a_read_enable && !a_write_enable) begin
                    av = 1'b1; ad = mem_m[k][a_address];
                end
                if (b_read_enable) begin
                    bv = 1'b1; bd = mem_m[k][b_address];
                end
                if (a_write_enable) begin
                    bm = {{8{a_byte_enable[1]}}, {8{a_byte_enable[0]}}};
                    mem_m[k][a_address] = (mem_m[k][a_address] & ~bm) | (a_data_in & bm);
                end
            end
            ring_v[k][0][edge_n & 3] = av; ring_d[k][0][edge_n & 3] = ad;
            ring_v[k][1][edge_n & 3] = bv; ring_d[k][1][edge_n & 3] = bd;
            src = (edge_n - (lat_of(k) - 1)) & 3;
            for (int p = 0; p < 2; p++) begin
                exp_v[k][p] = ring_v[k][p][src];
                if (ring_v[k][p][src]) exp_d[k][p] = ring_d[k][p][src];
            end
        end
        exp_busy[k] = (busy_left[k] > 0);
    endtask

    always @(posedge clk) begin
        if (reset) live = 1'b1;
        for (int k = 0; k < NI; k++) model_edge(k);
        edge_n++;
    end

    bit saw_busy2 = 0;

    always @(negedge clk) begin
        if (live) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("busy[%0d]", k), 32'(busy_o[k]), 32'(exp_busy[k]));
                check($sformatf("a_valid[%0d]", k), 32'(a_dv[k]), 32'(exp_v[k][0]));
                check($sformatf("a_data[%0d]", k), 32'(a_do[k]), 32'(exp_d[k][0]));
                check($sformatf("b_valid[%0d]", k), 32'(b_dv[k]), 32'(exp_v[k][1]));
                check($sformatf("b_data[%0d]", k), 32'(b_do[k]), 32'(exp_d[k][1]));
            end
            if (busy_o[2]) saw_busy2 = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_write_enable = 1'b0;
        a_read_enable  = 1'b0;
        b_read_enable  = 1'b0;
        a_byte_enable  = 2'b00;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [1:0] be);
        a_address = addr; a_data_in = data; a_byte_enable = be; a_write_enable = 1'b1;
        tick();
        a_write_enable = 1'b0;
    endtask

    task automatic busy_run(output int n);
        n = 0;
        while (busy_o[0] && n < 100) begin
            n++;
            tick();
        end
    endtask

    // ---------------- directed sequence ----------------
    int n;

    initial begin
        reset = 1'b1; a_address = '0; a_data_in = '0; b_address = '0;
        idle();
        tick(); tick();
        check("reset_a_valid", 32'(a_dv[0]), 32'd0);
        check("reset_a_data", 32'(a_do[1]), 32'd0);
        check("reset_busy_noclear", 32'(busy_o[2]), 32'd0);
        reset = 1'b0;
        busy_run(n);
        check("first_clear_len", 32'(n), 32'd16);

        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 16'hFFFF, 2'b11);

        // Reset pulse with a write held on address 3 throughout the clear.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_address = 4'd3; a_data_in = 16'h1234; a_byte_enable = 2'b11; a_write_enable = 1'b1;
        busy_run(n);
        idle();
        check("clear_len", 32'(n), 32'd16);
        check("busy_lat2_done", 32'(busy_o[1]), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            a_address = AW'(i); a_read_enable = 1'b1;
            tick();
            check($sformatf("cleared[%0d]", i), 32'(a_do[0]), 32'h0000);
            check($sformatf("kept[%0d]", i), 32'(a_do[2]), (i == 3) ? 32'h1234 : 32'hFFFF);
        end
        idle();
        tick();

        // Byte enables.
        wr(4'd5, 16'hABCD, 2'b11);
        wr(4'd5, 16'h1200, 2'b10);
        check("be_valid_before", 32'(a_dv[0]), 32'd0);
        a_address = 4'd5; a_read_enable = 1'b1;
        tick();
        a_read_enable = 1'b0;
        check("be_data", 32'(a_do[0]), 32'h12CD);
        check("be_valid", 32'(a_dv[0]), 32'd1);
        tick();
        check("be_valid_drop", 32'(a_dv[0]), 32'd0);
        check("be_hold", 32'(a_do[0]), 32'h12CD);

        // Latency-2 pipelining on port B.
        wr(4'd1, 16'h0011, 2'b11);
        wr(4'd2, 16'h0022, 2'b11);
        wr(4'd3, 16'h0033, 2'b11);
        b_address = 4'd1; b_read_enable = 1'b1;
        tick();
        check("l2_e1_valid", 32'(b_dv[1]), 32'd0);
        check("l1_e1_data", 32'(b_do[0]), 32'h0011);
        b_address = 4'd2;
        tick();
        check("l2_e2_valid", 32'(b_dv[1]), 32'd1);
        check("l2_e2_data", 32'(b_do[1]), 32'h0011);
        b_address = 4'd3;
        tick();
        b_read_enable = 1'b0;
        check("l2_e3_data", 32'(b_do[1]), 32'h0022);
        tick();
        check("l2_e4_valid", 32'(b_dv[1]), 32'd1);
        check("l2_e4_data", 32'(b_do[1]), 32'h0033);
        tick();
        check("l2_e5_valid", 32'(b_dv[1]), 32'd0);
        check("l2_e5_hold", 32'(b_do[1]), 32'h0033);

        // Same-address collision: read-first.
        wr(4'd7, 16'h0042, 2'b11);
        a_address = 4'd7; a_data_in = 16'h0099; a_byte_enable = 2'b11; a_write_enable = 1'b1;
        b_address = 4'd7; b_read_enable = 1'b1;
        tick();
        a_write_enable = 1'b0;
        check("coll_old", 32'(b_do[0]), 32'h0042);
        tick();
        b_read_enable = 1'b0;
        check("coll_new", 32'(b_do[0]), 32'h0099);
        tick(); tick();

        // Write priority over a same-cycle port A read.
        a_address = 4'd9; a_data_in = 16'h5A5A; a_byte_enable = 2'b11;
        a_write_enable = 1'b1; a_read_enable = 1'b1;
        tick();
        idle();
        check("prio_valid_l1", 32'(a_dv[0]), 32'd0);
        tick();
        check("prio_valid_l2", 32'(a_dv[1]), 32'd0);
        a_read_enable = 1'b1;
        tick();
        a_read_enable = 1'b0;
        check("prio_written", 32'(a_do[0]), 32'h5A5A);
        tick(); tick();

        // Reset mid-clear restarts the full sequence.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("midclear_busy", 32'(busy_o[0]), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        busy_run(n);
        check("restart_len", 32'(n), 32'd16);
        a_address = 4'd5; a_read_enable = 1'b1;
        tick();
        idle();
        check("after_clear_5", 32'(a_do[0]), 32'h0000);
        check("survive_5", 32'(a_do[2]), 32'h12CD);
        tick(); tick();
        check("noclear_never_busy", 32'(saw_busy2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
